// File: rtl/addx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addx_pkg
// Description : Shared types and constants for the ADDX functional unit:
//               operation enum, opcode constants, FSM state enum, and the
//               custom-0 instruction encodings consumed by the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package addx_pkg;

    // Operation selector carried from issue to the unit.
    typedef enum logic [1:0] {
        ADDX_ADD  = 2'b00,   // a + b, carry dropped
        ADDX_ADDS = 2'b01,   // a + b, saturating unsigned
        ADDX_BSUM = 2'b10,   // sum of all byte lanes of a and b (iterative)
        ADDX_RSVD = 2'b11    // reserved, yields zero, never traps
    } addx_op_e;

    // Raw opcode values for code that handles op_i as plain bits.
    localparam logic [1:0] ADDX_OP_ADD  = 2'b00;
    localparam logic [1:0] ADDX_OP_ADDS = 2'b01;
    localparam logic [1:0] ADDX_OP_BSUM = 2'b10;
    localparam logic [1:0] ADDX_OP_RSVD = 2'b11;

    // Unit FSM: single-cycle ops never leave IDLE.
    typedef enum logic {
        IDLE = 1'b0,
        BSUM = 1'b1
    } addx_state_e;

    // Custom-0 instruction encodings recognised by the decoder.
    localparam logic [6:0] ADDX_OPCODE_CUSTOM0 = 7'b000_1011;
    localparam logic [6:0] ADDX_FUNCT7         = 7'b000_0100;
    localparam logic [2:0] ADDX_FUNCT3_ADD     = 3'b000;
    localparam logic [2:0] ADDX_FUNCT3_ADDS    = 3'b001;
    localparam logic [2:0] ADDX_FUNCT3_BSUM    = 3'b010;

    // True for operations that occupy the unit for more than one cycle.
    function automatic logic addx_is_iterative(input addx_op_e op);
        return (op == ADDX_BSUM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/addx_unit.sv
`default_nettype none
// ============================================================================
// Module      : addx_unit
// Description : ADDX execute-stage functional unit. Accepts one instruction
//               per cycle when idle; ADD/ADDS/reserved complete with latency
//               1, BSUM iterates one byte lane per cycle (latency NB+1).
//               Results leave on a dedicated writeback port.
// Revision    : 1.0 - initial release
//
// Ports
//   clk_i        in   1              core clock
//   rst_ni       in   1              asynchronous reset, active-low
//   flush_i      in   1              kill in-flight op, block acceptance
//   valid_i      in   1              issue presents an ADDX instruction
//   ready_o      out  1              unit can accept this cycle
//   op_i         in   2              addx_op_e
//   operand_a_i  in   XLEN           rs1 value
//   operand_b_i  in   XLEN           rs2 value
//   trans_id_i   in   TRANS_ID_BITS  scoreboard tag
//   valid_o      out  1              writeback valid, one-cycle pulse
//   result_o     out  XLEN           writeback data (held between pulses)
//   trans_id_o   out  TRANS_ID_BITS  writeback tag (held between pulses)
// ============================================================================
module addx_unit
    import addx_pkg::*;
#(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter bit          ENABLE_ADDX   = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [1:0]               op_i,
    input  logic [XLEN-1:0]          operand_a_i,
    input  logic [XLEN-1:0]          operand_b_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic                     valid_o,
    output logic [XLEN-1:0]          result_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o
);

    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned CW    = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned ACC_W = $clog2(2 * NB * 255 + 1);

    generate
        if (ENABLE_ADDX) begin : g_addx
            addx_state_e              state_q, state_d;
            logic [XLEN-1:0]          a_q, a_d;
            logic [XLEN-1:0]          b_q, b_d;
            logic [TRANS_ID_BITS-1:0] tag_q, tag_d;
            logic [ACC_W-1:0]         acc_q, acc_d;
            logic [CW-1:0]            cnt_q, cnt_d;
            logic                     valid_q, valid_d;
            logic [XLEN-1:0]          result_q, result_d;
            logic [TRANS_ID_BITS-1:0] trans_id_q, trans_id_d;

            logic                     accept;
            addx_op_e                 op;
            logic [XLEN:0]            sum_ext;
            logic [XLEN-1:0]          a_shift;
            logic [XLEN-1:0]          b_shift;
            logic [8:0]               lane_sum;
            logic [ACC_W-1:0]         acc_next;

            assign op      = addx_op_e'(op_i);
            assign ready_o = (state_q == IDLE);
            assign accept  = valid_i & ready_o & ~flush_i;

            // Full-width add with carry-out kept for the saturating variant.
            assign sum_ext = {1'b0, operand_a_i} + {1'b0, operand_b_i};

            // Current byte lane of each latched operand, selected by cnt.
            assign a_shift  = a_q >> {cnt_q, 3'b000};
            assign b_shift  = b_q >> {cnt_q, 3'b000};
            assign lane_sum = {1'b0, a_shift[7:0]} + {1'b0, b_shift[7:0]};
            assign acc_next = acc_q + ACC_W'(lane_sum);

            always_comb begin
                state_d    = state_q;
                a_d        = a_q;
                b_d        = b_q;
                tag_d      = tag_q;
                acc_d      = acc_q;
                cnt_d      = cnt_q;
                valid_d    = 1'b0;
                result_d   = result_q;
                trans_id_d = trans_id_q;

                case (state_q)
                    IDLE: begin
                        if (accept) begin
                            if (addx_is_iterative(op)) begin
                                state_d = BSUM;
                                a_d     = operand_a_i;
                                b_d     = operand_b_i;
                                tag_d   = trans_id_i;
                                acc_d   = '0;
                                cnt_d   = '0;
                            end else begin
                                valid_d    = 1'b1;
                                trans_id_d = trans_id_i;
                                case (op)
                                    ADDX_ADD:  result_d = sum_ext[XLEN-1:0];
                                    ADDX_ADDS: result_d = sum_ext[XLEN] ? '1
                                                                        : sum_ext[XLEN-1:0];
                                    default:   result_d = '0;
                                endcase
                            end
                        end
                    end

                    BSUM: begin
                        if (flush_i) begin
                            // Killed op: return to idle without a writeback.
                            state_d = IDLE;
                            acc_d   = '0;
                            cnt_d   = '0;
                        end else if (cnt_q == CW'(NB - 1)) begin
                            // Last lane folds straight into the result.
                            state_d    = IDLE;
                            valid_d    = 1'b1;
                            result_d   = XLEN'(acc_next);
                            trans_id_d = tag_q;
                            acc_d      = '0;
                            cnt_d      = '0;
                        end else begin
                            acc_d = acc_next;
                            cnt_d = cnt_q + 1'b1;
                        end
                    end

                    default: state_d = IDLE;
                endcase
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    state_q    <= IDLE;
                    a_q        <= '0;
                    b_q        <= '0;
                    tag_q      <= '0;
                    acc_q      <= '0;
                    cnt_q      <= '0;
                    valid_q    <= 1'b0;
                    result_q   <= '0;
                    trans_id_q <= '0;
                end else begin
                    state_q    <= state_d;
                    a_q        <= a_d;
                    b_q        <= b_d;
                    tag_q      <= tag_d;
                    acc_q      <= acc_d;
                    cnt_q      <= cnt_d;
                    valid_q    <= valid_d;
                    result_q   <= result_d;
                    trans_id_q <= trans_id_d;
                end
            end

            assign valid_o    = valid_q;
            assign result_o   = result_q;
            assign trans_id_o = trans_id_q;
        end else begin : g_no_addx
            // Unit absent: never ready, never writes back, holds no state.
            logic unused_inputs;
            assign unused_inputs = ^{clk_i, rst_ni, flush_i, valid_i, op_i,
                                     operand_a_i, operand_b_i, trans_id_i};
            assign ready_o    = 1'b0;
            assign valid_o    = 1'b0;
            assign result_o   = '0;
            assign trans_id_o = '0;
        end
    endgenerate

endmodule
`default_nettype wire
